// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised IEEE-754 binary adder/subtractor, 3-stage pipeline.
//   Stage 1 unpacks, classifies, swaps and aligns. Stage 2 adds or subtracts and counts leading zeros.
//   Stage 3 normalises, rounds to nearest-even, packs and registers the outputs.
//   Special operands (NaN, inf) are resolved in stage 1 and carried down the pipe.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand beat handshake (a, b, op; op=1 add, op=0 subtract)
//   out_valid/out_ready      result handshake (result, flag_invalid/overflow/inexact)
// All stages advance together when the output register is empty or being drained.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    input  logic                      op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic                      flag_invalid,
    output logic                      flag_overflow,
    output logic                      flag_inexact
);

    localparam int unsigned W   = 1 + EXP_W + FRAC_W;
    localparam int unsigned DW  = FRAC_W + 4;          // hidden, frac, G, R, S
    localparam int unsigned SHW = $clog2(DW + 1);
    localparam int unsigned EW2 = EXP_W + 2;           // headroom for carry / rounding

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Leading-zero count; the highest set bit wins because it is visited last.
    function automatic logic [SHW-1:0] lzc_f(input logic [DW-1:0] v);
        lzc_f = SHW'(DW);
        for (int i = 0; i < int'(DW); i++) begin
            if (v[i]) lzc_f = SHW'(int'(DW) - 1 - i);
        end
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- stage 1: unpack / classify / swap / align ----------------
    logic              sa, sb_eff;
    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff;
    logic [FRAC_W-1:0] fa, fb;
    logic              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic [DW-1:0]     sig_a, sig_b, big_sig, small_sig, small_al;
    logic [EXP_W-1:0]  big_exp, small_exp, exp_diff;
    logic              big_sign;
    logic [SHW-1:0]    shift_amt;
    logic [2*DW-1:0]   ext;
    logic              spec_c, spec_inv_c;
    logic [W-1:0]      spec_res_c;

    always_comb begin
        sa        = a[W-1];
        sb_eff    = b[W-1] ^ ~op;
        ea        = a[W-2:FRAC_W];
        eb        = b[W-2:FRAC_W];
        fa        = a[FRAC_W-1:0];
        fb        = b[FRAC_W-1:0];
        a_nan     = (&ea) && (|fa);
        b_nan     = (&eb) && (|fb);
        a_snan    = a_nan && !fa[FRAC_W-1];
        b_snan    = b_nan && !fb[FRAC_W-1];
        a_inf     = (&ea) && !(|fa);
        b_inf     = (&eb) && !(|fb);
        // subnormals use exponent 1 with a zero hidden bit
        ea_eff    = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff    = (eb == '0) ? EXP_W'(1) : eb;
        sig_a     = {(ea != '0), fa, 3'b000};
        sig_b     = {(eb != '0), fb, 3'b000};

        big_sign  = sa;
        big_exp   = ea_eff;
        big_sig   = sig_a;
        small_exp = eb_eff;
        small_sig = sig_b;
        if (a[W-2:0] < b[W-2:0]) begin
            big_sign  = sb_eff;
            big_exp   = eb_eff;
            big_sig   = sig_b;
            small_exp = ea_eff;
            small_sig = sig_a;
        end

        // clamping the shift at DW pushes the whole operand into the sticky half
        exp_diff  = big_exp - small_exp;
        shift_amt = (32'(exp_diff) > DW) ? SHW'(DW) : SHW'(exp_diff);
        ext       = {small_sig, {DW{1'b0}}} >> shift_amt;
        small_al  = {ext[2*DW-1:DW+1], ext[DW] | (|ext[DW-1:0])};

        spec_c     = 1'b0;
        spec_inv_c = 1'b0;
        spec_res_c = '0;
        if (a_nan || b_nan) begin
            spec_c     = 1'b1;
            spec_res_c = QNAN;
            spec_inv_c = a_snan || b_snan;
        end else if (a_inf && b_inf && (sa != sb_eff)) begin
            spec_c     = 1'b1;
            spec_res_c = QNAN;
            spec_inv_c = 1'b1;
        end else if (a_inf) begin
            spec_c     = 1'b1;
            spec_res_c = a;
        end else if (b_inf) begin
            spec_c     = 1'b1;
            spec_res_c = {sb_eff, b[W-2:0]};
        end
    end

    logic              s1_valid, s1_special, s1_spec_inv, s1_sign, s1_zero_sign, s1_sub;
    logic [W-1:0]      s1_spec_res;
    logic [EXP_W-1:0]  s1_exp;
    logic [DW-1:0]     s1_big, s1_small;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_special   <= 1'b0;
            s1_spec_inv  <= 1'b0;
            s1_spec_res  <= '0;
            s1_sign      <= 1'b0;
            s1_zero_sign <= 1'b0;
            s1_sub       <= 1'b0;
            s1_exp       <= '0;
            s1_big       <= '0;
            s1_small     <= '0;
        end else if (en) begin
            s1_valid     <= in_valid;
            s1_special   <= spec_c;
            s1_spec_inv  <= spec_inv_c;
            s1_spec_res  <= spec_res_c;
            s1_sign      <= big_sign;
            s1_zero_sign <= sa & sb_eff;   // only -0 + -0 keeps a negative zero
            s1_sub       <= sa ^ sb_eff;
            s1_exp       <= big_exp;
            s1_big       <= big_sig;
            s1_small     <= small_al;
        end
    end

    // ---------------- stage 2: add / subtract, leading-zero count ----------------
    logic [DW:0]    sum_c;
    logic [SHW-1:0] lzc_c;

    always_comb begin
        sum_c = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                       : ({1'b0, s1_big} + {1'b0, s1_small});
        lzc_c = lzc_f(sum_c[DW-1:0]);
    end

    logic              s2_valid, s2_special, s2_spec_inv, s2_sign, s2_zero_sign;
    logic [W-1:0]      s2_spec_res;
    logic [EXP_W-1:0]  s2_exp;
    logic [DW:0]       s2_sum;
    logic [SHW-1:0]    s2_lzc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            s2_special   <= 1'b0;
            s2_spec_inv  <= 1'b0;
            s2_spec_res  <= '0;
            s2_sign      <= 1'b0;
            s2_zero_sign <= 1'b0;
            s2_exp       <= '0;
            s2_sum       <= '0;
            s2_lzc       <= '0;
        end else if (en) begin
            s2_valid     <= s1_valid;
            s2_special   <= s1_special;
            s2_spec_inv  <= s1_spec_inv;
            s2_spec_res  <= s1_spec_res;
            s2_sign      <= s1_sign;
            s2_zero_sign <= s1_zero_sign;
            s2_exp       <= s1_exp;
            s2_sum       <= sum_c;
            s2_lzc       <= lzc_c;
        end
    end

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [DW-1:0]     m_c;
    logic [EW2-1:0]    e_c;
    logic [31:0]       sh_c;
    logic              inc_c, hid_c;
    logic [FRAC_W+1:0] rnd_c;
    logic [FRAC_W-1:0] frac_c;
    logic [W-1:0]      res_c;
    logic              inv_c, ovf_c, inx_c;

    always_comb begin
        m_c    = '0;
        e_c    = '0;
        sh_c   = '0;
        inc_c  = 1'b0;
        hid_c  = 1'b0;
        rnd_c  = '0;
        frac_c = '0;
        res_c  = '0;
        inv_c  = 1'b0;
        ovf_c  = 1'b0;
        inx_c  = 1'b0;
        if (s2_special) begin
            res_c = s2_spec_res;
            inv_c = s2_spec_inv;
        end else if (s2_sum == '0) begin
            res_c = {s2_zero_sign, {(W-1){1'b0}}};
        end else begin
            if (s2_sum[DW]) begin
                m_c = {s2_sum[DW:2], |s2_sum[1:0]};
                e_c = EW2'(s2_exp) + EW2'(1);
            end else begin
                // never normalise below exponent 1: what remains is subnormal
                sh_c = (32'(s2_lzc) < 32'(s2_exp) - 32'd1) ? 32'(s2_lzc) : 32'(s2_exp) - 32'd1;
                m_c  = s2_sum[DW-1:0] << sh_c;
                e_c  = EW2'(32'(s2_exp) - sh_c);
            end
            inc_c = m_c[2] & (m_c[1] | m_c[0] | m_c[3]);
            rnd_c = {1'b0, m_c[DW-1:3]} + (FRAC_W+2)'(inc_c);
            if (rnd_c[FRAC_W+1]) begin
                hid_c  = 1'b1;
                frac_c = '0;
                e_c    = e_c + EW2'(1);
            end else begin
                hid_c  = rnd_c[FRAC_W];
                frac_c = rnd_c[FRAC_W-1:0];
            end
            inx_c = |m_c[2:0];
            if (e_c >= EW2'({EXP_W{1'b1}})) begin
                res_c = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                ovf_c = 1'b1;
                inx_c = 1'b1;
            end else begin
                res_c = {s2_sign, (hid_c ? e_c[EXP_W-1:0] : {EXP_W{1'b0}}), frac_c};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            result        <= '0;
            flag_invalid  <= 1'b0;
            flag_overflow <= 1'b0;
            flag_inexact  <= 1'b0;
        end else if (en) begin
            out_valid     <= s2_valid;
            result        <= res_c;
            flag_invalid  <= inv_c;
            flag_overflow <= ovf_c;
            flag_inexact  <= inx_c;
        end
    end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised IEEE-754 binary floating-point adder/subtractor: 3-stage pipeline with valid/ready handshake, full special-value handling and status flags. It is the pipelined, width-generic successor to the team's combinational FP32 add/sub. It sits in the FP datapath between operand issue and writeback. Default configuration is binary32; the same RTL serves binary16 and bfloat16.

Parameters:
EXP_W, 8, exponent field width (>=3)
FRAC_W, 23, stored fraction width, excluding the hidden bit (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  1+EXP_W+FRAC_W  operand A {sign, exp, frac}
b  input  1+EXP_W+FRAC_W  operand B
op  input  1  1 = A+B, 0 = A-B (sign of B inverted)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  1+EXP_W+FRAC_W  rounded sum/difference
flag_invalid  output  1  inf-inf or signalling NaN input
flag_overflow  output  1  rounded magnitude exceeded max finite
flag_inexact  output  1  any nonzero bit discarded (G|R|S) or overflow

Behaviour:
- Reset: all stage valid bits, out_valid, result and flags clear to 0 immediately on rst assertion, irrespective of clk; in-flight beats are discarded. in_ready is 1 throughout reset and after it.
- Handshake: a beat transfers on in_valid&&in_ready; a result transfers on out_valid&&out_ready. Global enable en = !out_valid || out_ready; in_ready = en. When en=0 all stages hold, and result/flags stay stable while out_valid=1 and out_ready=0. No beat is lost or duplicated.
- Latency: exactly 3 cycles from input transfer to out_valid under en=1; throughput one beat per cycle.
- Stage 1 (unpack/align): classify zero, subnormal, normal, inf, NaN. Subnormals take hidden bit 0 and effective exponent 1. Effective B sign = b.sign ^ !op. Swap so A has the larger magnitude; result sign = larger operand's sign. Right-shift the smaller significand by the exponent difference into a FRAC_W+4-bit datapath (hidden, frac, G, R) with sticky = OR of all bits shifted out. A difference > FRAC_W+3 gives a zero significand with sticky = (small != 0).
- Stage 2 (add/sub): add or subtract by effective signs in FRAC_W+5 bits (one carry bit); leading-zero count of the sum.
- Stage 3 (normalise/round/pack): on carry, shift right 1 and fold the dropped bit into sticky. Otherwise left-shift by LZC, limited so the exponent does not go below 1; a result whose exponent stays at 1 without a hidden bit is subnormal (gradual underflow). Round to nearest, ties-to-even: increment when G && (R || S || lsb). A rounding carry-out renormalises and increments the exponent.
- Exact cancellation (x - x) yields +0. (-0)+(-0) and (-0)-(+0) yield -0.
- Overflow: if the rounded exponent is all-ones or above, the output is ±inf with flag_overflow=1 and flag_inexact=1.
- Specials take priority over the arithmetic path; they are decided in stage 1 and carried forward:
  - Any NaN input gives the canonical qNaN {0, all-ones, 1, zeros}. flag_invalid=1 only if an input is signalling (frac MSB=0).
  - inf + (-inf) after op gives the canonical qNaN, flag_invalid=1.
  - inf with a finite operand gives that inf, with no flags.
- Flags are per-result and travel with it; they are not sticky across beats.

Test Plan:
- a=0x3F800000, b=0x3F800000, op=1, out_ready=1 -> result=0x40000000 exactly 3 cycles after transfer, all flags 0.
- a=0x3F800000, b=0x3F800000, op=0 -> result=0x00000000. a=0x80000000, b=0x00000000, op=0 -> result=0x80000000.
- a=0x3F800000, b=0x33800000 (2^-24, exact tie), op=1 -> result=0x3F800000, flag_inexact=1. b=0x33800001 -> result=0x3F800001, flag_inexact=1.
- a=0x7F7FFFFF, b=0x7F7FFFFF, op=1 -> result=0x7F800000, overflow=1, inexact=1. a=0x7F800000, b=0x7F800000, op=0 -> result=0x7FC00000, invalid=1. a=0x7F800001 (sNaN) -> result=0x7FC00000, invalid=1.
- Subnormals: a=0x00000001, b=0x00000001, op=1 -> result=0x00000002. a=0x00800000, b=0x00000001, op=0 -> result=0x007FFFFF, no flags.
- Back-to-back random beats with in_valid=1 and out_ready held 0 for 5 cycles: in_ready=0 while the pipeline is full and result stays stable; the output sequence matches the input order with none dropped. Assert rst mid-stream: out_valid=0 without waiting for a clk edge, and the first post-reset beat emerges after 3 cycles. Rerun with EXP_W=5, FRAC_W=10: 0x3C00+0x3C00 -> 0x4000.
